// File: rtl/klotski_pkg.sv
// =============================================================================
// Module  : klotski_pkg
// Brief   : Shared types, constants and index helpers for the Klotski executor.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package klotski_pkg;

    typedef logic [0:3][0:3][3:0] board_t;

    localparam logic [3:0] BLANK = 4'd0;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BLANK   = 2'd1,
        ERR_ADJ     = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_READY = 3'd1,
        S_CHECK = 3'd2,
        S_APPLY = 3'd3,
        S_HOLD  = 3'd4,
        S_ERROR = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    function automatic logic [1:0] idx_row(input logic [3:0] idx);
        return idx[3:2];
    endfunction

    function automatic logic [1:0] idx_col(input logic [3:0] idx);
        return idx[1:0];
    endfunction

    // Goal: tiles 1..15 in reading order, blank in the bottom-right corner.
    function automatic logic is_goal(input board_t b);
        logic v_ok;
        v_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (b[2'(k / 4)][2'(k % 4)] != ((k == 15) ? BLANK : 4'(k + 1))) begin
                v_ok = 1'b0;
            end
        end
        return v_ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/klotski_move_checker.sv
// =============================================================================
// Module  : klotski_move_checker
// Brief   : Combinational legality check of one slide on a 4x4 board.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module klotski_move_checker
    import klotski_pkg::*;
(
    input  logic [0:3][0:3][3:0] i_board,
    input  logic [3:0]           i_start_block,
    input  logic [3:0]           i_end_block,
    output logic                 o_valid,
    output err_e                 o_err
);

    logic [1:0] w_rs;
    logic [1:0] w_cs;
    logic [1:0] w_re;
    logic [1:0] w_ce;
    logic [3:0] w_src_val;
    logic [3:0] w_dst_val;
    logic [1:0] w_dr;
    logic [1:0] w_dc;
    logic [2:0] w_dist;

    always_comb begin
        w_rs      = idx_row(i_start_block);
        w_cs      = idx_col(i_start_block);
        w_re      = idx_row(i_end_block);
        w_ce      = idx_col(i_end_block);
        w_src_val = i_board[w_rs][w_cs];
        w_dst_val = i_board[w_re][w_ce];
        w_dr      = (w_rs > w_re) ? (w_rs - w_re) : (w_re - w_rs);
        w_dc      = (w_cs > w_ce) ? (w_cs - w_ce) : (w_ce - w_cs);
        // Manhattan distance on (row, col) so index 3->4 counts as a wrap, not a neighbour.
        w_dist    = {1'b0, w_dr} + {1'b0, w_dc};

        o_valid = 1'b0;
        o_err   = ERR_NONE;
        if ((w_src_val == BLANK) || (w_dst_val != BLANK)) begin
            o_err = ERR_BLANK;
        end else if (w_dist != 3'd1) begin
            o_err = ERR_ADJ;
        end else begin
            o_valid = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/klotski_move_executor.sv
// =============================================================================
// Module  : klotski_move_executor
// Brief   : Holds the live board, validates/applies solver moves, paces the
//           solver with o_continue and grades the final board.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module klotski_move_executor
    import klotski_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic [0:3][0:3][3:0] i_klotski,
    input  logic                 i_en,
    input  logic [3:0]           i_start_block,
    input  logic [3:0]           i_end_block,
    input  logic                 i_finished,
    output logic                 o_continue,
    output logic [0:3][0:3][3:0] o_board,
    output logic [CNT_W-1:0]     o_move_count,
    output logic                 o_busy,
    output logic                 o_error,
    output logic [1:0]           o_err_code,
    output logic                 o_solved
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

    state_e              r_state;
    state_e              w_state_nxt;
    board_t              r_board;
    logic [3:0]          r_src;
    logic [3:0]          r_dst;
    logic [CNT_W-1:0]    r_count;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_pend;
    logic                r_error;
    err_e                r_err_code;
    logic                r_solved;

    logic                w_chk_valid;
    err_e                w_chk_err;
    logic                w_latch;
    logic                w_apply;
    logic                w_err_set;
    err_e                w_err_code;
    logic                w_pend_set;
    logic                w_to_done;
    logic                w_continue;
    logic                w_busy;

    klotski_move_checker u_checker (
        .i_board       (r_board),
        .i_start_block (r_src),
        .i_end_block   (r_dst),
        .o_valid       (w_chk_valid),
        .o_err         (w_chk_err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_apply     = 1'b0;
        w_err_set   = 1'b0;
        w_err_code  = ERR_NONE;
        w_pend_set  = 1'b0;
        w_to_done   = 1'b0;
        w_continue  = 1'b0;
        w_busy      = (r_state == S_CHECK) || (r_state == S_APPLY) || (r_state == S_HOLD);

        if (i_load) begin
            w_state_nxt = S_READY;
        end else begin
            case (r_state)
                S_READY: begin
                    if (i_en) begin
                        w_latch     = 1'b1;
                        w_pend_set  = i_finished;
                        w_state_nxt = S_CHECK;
                    end else if (i_finished) begin
                        w_to_done   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_CHECK: begin
                    w_pend_set = i_finished;
                    if (!w_chk_valid) begin
                        w_err_set   = 1'b1;
                        w_err_code  = w_chk_err;
                        w_state_nxt = S_ERROR;
                    end else if (i_en) begin
                        w_err_set   = 1'b1;
                        w_err_code  = ERR_OVERRUN;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_APPLY;
                    end
                end
                S_APPLY: begin
                    // The checked move commits even if an overrun arrives alongside it.
                    w_apply    = 1'b1;
                    w_pend_set = i_finished;
                    if (i_en) begin
                        w_err_set   = 1'b1;
                        w_err_code  = ERR_OVERRUN;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    w_pend_set = i_finished;
                    if (i_en) begin
                        w_err_set   = 1'b1;
                        w_err_code  = ERR_OVERRUN;
                        w_state_nxt = S_ERROR;
                    end else if (r_hold == '0) begin
                        w_continue = 1'b1;
                        if (r_pend || i_finished) begin
                            w_to_done   = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_READY;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_board    <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_count    <= '0;
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_solved   <= 1'b0;
        end else if (i_load) begin
            r_board    <= i_klotski;
            r_count    <= '0;
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_solved   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_src <= i_start_block;
                r_dst <= i_end_block;
            end
            if (w_apply) begin
                r_board[idx_row(r_dst)][idx_col(r_dst)] <= r_board[idx_row(r_src)][idx_col(r_src)];
                r_board[idx_row(r_src)][idx_col(r_src)] <= BLANK;
                if (r_count != c_CNT_MAX) begin
                    r_count <= r_count + CNT_W'(1);
                end
                r_hold <= c_HOLD_LOAD;
            end else if ((r_state == S_HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - c_HOLD_W'(1);
            end
            if (w_continue) begin
                r_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_pend <= 1'b1;
            end
            if (w_err_set && !r_error) begin
                r_error    <= 1'b1;
                r_err_code <= w_err_code;
            end
            if (w_to_done) begin
                r_solved <= is_goal(r_board);
            end
        end
    end

    assign o_continue   = w_continue;
    assign o_board      = r_board;
    assign o_move_count = r_count;
    assign o_busy       = w_busy;
    assign o_error      = r_error;
    assign o_err_code   = r_err_code;
    assign o_solved     = r_solved;

endmodule

`default_nettype wire

// File: doc/klotski_move_executor.md
# klotski_move_executor

Consumer end of the solver's move stream. Holds the live 4x4 board, accepts one move per `i_en` pulse and validates it (tiles adjacent, destination blank). It applies valid moves, holds each result for a programmable display interval, then returns a one-cycle `o_continue` pulse to pace the solver. When the solver signals completion, it checks the board against the goal and reports solved or error status to the top level and display.

## Interface
Parameters:
- `HOLD_CYCLES`, 50_000_000: cycles each applied move is held before `o_continue` (0 allowed).
- `CNT_W`, 16: move counter width.

Ports:
- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_load` input 1: load `i_klotski` as the new board.
- `i_klotski` input [0:3][0:3][3:0]: initial board, row-major, value 0 = blank.
- `i_en` input 1: move-valid strobe from the solver.
- `i_start_block` input 4: source cell index, `{row[1:0], col[1:0]}`.
- `i_end_block` input 4: destination cell index, same encoding.
- `i_finished` input 1: solver-done pulse.
- `o_continue` output 1: one-cycle ack; the solver may issue the next move.
- `o_board` output [0:3][0:3][3:0]: current board, registered.
- `o_move_count` output `CNT_W`: number of applied moves, saturating.
- `o_busy` output 1: high in CHECK, APPLY and HOLD.
- `o_error` output 1: sticky error flag.
- `o_err_code` output 2: 0 none, 1 blank violation, 2 not adjacent, 3 overrun.
- `o_solved` output 1: sticky; board matched the goal at finish.

## Operation
- States: S_EMPTY, S_READY, S_CHECK, S_APPLY, S_HOLD, S_ERROR, S_DONE.
- S_EMPTY: waits for `i_load`. `i_en` and `i_finished` are ignored.
- `i_load` in any state:
  - board <= `i_klotski`; count, `o_error`, `o_err_code`, `o_solved` and the pending-finish flag are cleared.
  - Next state is S_READY.
  - `i_load` has priority over every other input in the same cycle.
- S_READY, `i_en`=1: latch both indices, go to S_CHECK.
- S_CHECK: the checker evaluates the latched move.
  - Code 1 if the source cell is 0 or the destination cell is not 0.
  - Otherwise code 2 if |drow|+|dcol| != 1. This covers start==end and row wrap, e.g. 3->4 is illegal.
  - Any error goes to S_ERROR; a clean move goes to S_APPLY.
- S_APPLY: copy the source tile value to the destination, write 0 to the source, count += 1 (saturates at all-ones). Go to S_HOLD.
- S_HOLD: count down `HOLD_CYCLES`.
  - At expiry, pulse `o_continue` and return to S_READY.
  - If the pending-finish flag is set, go to S_DONE instead, still pulsing `o_continue`.
- `i_en` while `o_busy`=1: the move is dropped and the block enters S_ERROR with code 3.
- `i_finished`:
  - In S_READY: go to S_DONE.
  - While busy: set the pending-finish flag.
  - Same cycle as `i_en` in S_READY: the move is taken and finish becomes pending.
- S_DONE: `o_solved` <= (cell k holds k+1 for k=0..14, and cell 15 holds 0). The block stays in S_DONE until `i_load`.
- S_ERROR: the board is frozen, `o_continue` is never pulsed, and the state is held until `i_load`. The first error code wins.

## Timing
- Reset values:
  - All outputs 0, board all 0, state S_EMPTY.
  - The hold counter and pending-finish flag are cleared.
- The `i_en` sampling edge is cycle 0. CHECK is cycle 1, and `o_board` and `o_move_count` update at the edge ending cycle 2.
- `o_continue` asserts for exactly 1 cycle, `HOLD_CYCLES`+1 cycles after the APPLY edge. With `HOLD_CYCLES`=0 it asserts in the cycle right after APPLY.
- `o_error` is visible the cycle after CHECK, or the cycle after an overrun `i_en`.
- `o_solved` is valid the cycle after entering S_DONE.
- The hold counter is `$clog2(HOLD_CYCLES+1)` bits wide with a minimum of 1.
- Reset asserted mid-HOLD: no `o_continue` is issued, and the block returns to S_EMPTY immediately (asynchronous).

## Structure
- Package `klotski_pkg` holds:
  - `board_t` typedef.
  - `BLANK`=4'd0.
  - `err_e` enum: ERR_NONE, ERR_BLANK, ERR_ADJ, ERR_OVERRUN.
  - The state enum.
  - `idx_row()` and `idx_col()` functions.
- Sub-module `klotski_move_checker` is purely combinational.
  - Inputs: board and the two indices.
  - Outputs: a valid flag and an `err_e` code.
  - It is reused by the bench's reference model.

## Test plan
- Load the solved board with the blank swapped to cell 14 (cell 15 holds 15). Then send move 15->14 with `HOLD_CYCLES`=3 -> `o_board[3][2]`=15 and `[3][3]`=0 two cycles after `i_en`, `o_continue` exactly 4 cycles later, count=1.
- Follow up with `i_finished` -> `o_solved`=1, and further `i_en` is ignored.
- Blank at cell 4, move 3->4 -> `o_error`=1, code 2, board unchanged, no `o_continue`.
- Move from a non-blank cell into a non-blank cell -> code 1.
- Move from the blank cell -> code 1.
- Second `i_en` during S_HOLD -> code 3, first move still applied, count=1.
- `i_finished` in the same cycle as a valid `i_en` -> move applied, `o_continue` pulsed, then S_DONE; an unsolved board gives `o_solved`=0.
- `i_rst_n` low mid-HOLD -> all outputs 0 immediately.
- `i_load` in S_ERROR -> error cleared, new board visible the next cycle, count=0.
